// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction fields, controller state codes and
// datapath select encodings used by the multicycle controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;

    localparam logic [2:0] SRCB_B      = 3'b000;
    localparam logic [2:0] SRCB_FOUR   = 3'b001;
    localparam logic [2:0] SRCB_SEXT   = 3'b010;
    localparam logic [2:0] SRCB_SEXT2  = 3'b011;
    localparam logic [2:0] SRCB_ZEXT   = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    localparam logic [1:0] HC_NONE     = 2'b00;
    localparam logic [1:0] HC_ILLEGAL  = 2'b01;
    localparam logic [1:0] HC_TIMEOUT  = 2'b10;

    // States that issue a memory access and wait on mem_ready.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: steps the shared datapath through
// fetch/decode/execute/memory/writeback with a mem_ready handshake and timeout.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       halted,
    output logic [1:0] halt_cause,
    output logic [3:0] state
);

    localparam bit         TIMEOUT_EN = (WAIT_LIMIT != 0);
    localparam logic [7:0] LIMIT_M1   = 8'(WAIT_LIMIT - 1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic [1:0] cause_q;
    logic [1:0] entry_cause;
    logic       waiting;
    logic       timeout;
    logic       pc_write;
    logic       pc_write_cond;

    assign waiting = is_mem_state(cur) && !mem_ready;
    // The cycle in which the count would reach the limit is the last one waited.
    assign timeout = TIMEOUT_EN && waiting && (wait_cnt == LIMIT_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_FETCH;
            wait_cnt <= 8'd0;
            cause_q  <= HC_NONE;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= 8'd0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
            if ((nxt == S_HALT) && (cur != S_HALT))
                cause_q <= entry_cause;
        end
    end

    always_comb begin
        nxt         = cur;
        entry_cause = HC_NONE;
        case (cur)
            S_FETCH: begin
                if (mem_ready) begin
                    nxt = S_DECODE;
                end else if (timeout) begin
                    nxt         = S_HALT;
                    entry_cause = HC_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      nxt = S_MEM_ADDR;
                    OP_RTYPE:                          nxt = (funct == FN_JR) ? S_JR : S_R_EXEC;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: nxt = S_I_EXEC;
                    OP_BEQ:                            nxt = S_BRANCH;
                    OP_J:                              nxt = S_JUMP;
                    OP_JAL:                            nxt = S_JAL;
                    default: begin
                        nxt         = S_HALT;
                        entry_cause = HC_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    nxt = S_MEM_WB;
                end else if (timeout) begin
                    nxt         = S_HALT;
                    entry_cause = HC_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    nxt = S_FETCH;
                end else if (timeout) begin
                    nxt         = S_HALT;
                    entry_cause = HC_TIMEOUT;
                end
            end
            S_MEM_WB, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: nxt = S_FETCH;
            S_R_EXEC: nxt = S_R_WB;
            S_I_EXEC: nxt = S_I_WB;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_FETCH;
        endcase
    end

    // Output decode is gated by reset so an in-flight access drops at once.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_SEXT2;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SEXT;
                end
                S_MEM_RD: begin
                    mem_read  = 1'b1;
                    iord      = 1'b1;
                    mdr_write = mem_ready;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RD;
                    instr_done = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ((opcode == OP_ORI) || (opcode == OP_LUI)) ? ALUOP_IMM : ALUOP_ADD;
                    alu_src_b = (opcode == OP_ORI) ? SRCB_ZEXT : SRCB_SEXT;
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = M2R_PC;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_REGA;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc_en      = pc_write | (pc_write_cond & zero);
    assign halted     = (cur == S_HALT);
    assign halt_cause = cause_q;
    assign state      = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for the multicycle controller, plus directed
// halt, timeout and reset scenarios.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, mdr_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_op, pc_source, halt_cause;
    logic       alu_src_a, instr_done, halted;
    logic [2:0] alu_src_b;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .halted(halted),
        .halt_cause(halt_cause), .state(state)
    );

    typedef enum int {K_LW, K_SW, K_R, K_ADDI, K_ADDIU, K_ORI, K_LUI,
                      K_BEQ, K_J, K_JAL, K_JR} kind_t;

    typedef struct {
        int         cycles;
        logic [8:0] sig;    // {reg_write, reg_dst, mem_to_reg, pc_en, pc_source, mem_write}
        bit         chk_prev;
        logic [5:0] prev;   // {alu_src_a, alu_src_b, alu_op} one cycle before the last
        int         mdr;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    bit   done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: instruction class -> cycle count and last-cycle control values.
    function automatic exp_t model(kind_t k, logic z, int stalls);
        exp_t e;
        logic rw, pe, mw;
        logic [1:0] rd, m2r, ps;
        rw = 1'b0; pe = 1'b0; mw = 1'b0; rd = 2'b00; m2r = 2'b00; ps = 2'b00;
        e.chk_prev = 1'b1;
        e.prev     = 6'b0_011_00;
        e.mdr      = 0;
        e.cycles   = 3;
        case (k)
            K_LW:  begin e.cycles = 5; rw = 1'b1; m2r = 2'b01; e.mdr = 1; e.prev = 6'b0_000_00; end
            K_SW:  begin e.cycles = 4; mw = 1'b1; e.chk_prev = 1'b0; end
            K_R:   begin e.cycles = 4; rw = 1'b1; rd = 2'b01; e.prev = 6'b1_000_10; end
            K_ADDI, K_ADDIU: begin e.cycles = 4; rw = 1'b1; e.prev = 6'b1_010_00; end
            K_ORI: begin e.cycles = 4; rw = 1'b1; e.prev = 6'b1_100_11; end
            K_LUI: begin e.cycles = 4; rw = 1'b1; e.prev = 6'b1_010_11; end
            K_BEQ: begin pe = z; ps = 2'b01; end
            K_J:   begin pe = 1'b1; ps = 2'b10; end
            K_JAL: begin rw = 1'b1; rd = 2'b10; m2r = 2'b10; pe = 1'b1; ps = 2'b10; end
            default: begin pe = 1'b1; ps = 2'b11; end
        endcase
        e.cycles += stalls;
        e.sig = {rw, rd, m2r, pe, ps, mw};
        return e;
    endfunction

    task automatic set_instr(kind_t k);
        logic [5:0] f;
        f = 6'($urandom_range(0, 63));
        if (f == FN_JR) f = 6'b100001;
        funct = f;
        case (k)
            K_LW:    opcode = OP_LW;
            K_SW:    opcode = OP_SW;
            K_R:     opcode = OP_RTYPE;
            K_ADDI:  opcode = OP_ADDI;
            K_ADDIU: opcode = OP_ADDIU;
            K_ORI:   opcode = OP_ORI;
            K_LUI:   opcode = OP_LUI;
            K_BEQ:   opcode = OP_BEQ;
            K_J:     opcode = OP_J;
            K_JAL:   opcode = OP_JAL;
            default: begin opcode = OP_RTYPE; funct = FN_JR; end
        endcase
    endtask

    // Phase 0 is the fetch; loads and stores also access memory in phase 3.
    task automatic run_instr(kind_t k, logic z, bit allow_stall);
        int   st[5];
        int   tot;
        int   nph;
        exp_t base;
        base = model(k, z, 0);
        nph  = base.cycles;
        tot  = 0;
        for (int p = 0; p < 5; p++) begin
            st[p] = 0;
            if (allow_stall && (p == 0 || (p == 3 && (k == K_LW || k == K_SW))))
                st[p] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, LIMIT - 1));
            tot += st[p];
        end
        set_instr(k);
        zero = z;
        sbq.push_back(model(k, z, tot));
        for (int p = 0; p < nph; p++) begin
            if (p == 0 || (p == 3 && (k == K_LW || k == K_SW))) begin
                for (int s = 0; s < st[p]; s++) begin
                    mem_ready = 1'b0;
                    step();
                end
                mem_ready = 1'b1;
                step();
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
    endtask

    initial begin
        fork
            begin : stim
                int bad;
                reset = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE; funct = 6'b100001;
                @(negedge clk);
                check("rst_state", 32'(state), 32'(S_FETCH));
                check("rst_mem_read", 32'(mem_read), 32'd0);
                check("rst_ir_write", 32'(ir_write), 32'd0);
                check("rst_pc_en", 32'(pc_en), 32'd0);
                check("rst_halted", 32'(halted), 32'd0);
                check("rst_cause", 32'(halt_cause), 32'(HC_NONE));
                @(posedge clk); #1;
                reset = 1'b0;
                mon_en = 1'b1;

                run_instr(K_R, 1'b0, 1'b0);
                run_instr(K_LW, 1'b0, 1'b0);
                run_instr(K_SW, 1'b0, 1'b0);
                run_instr(K_BEQ, 1'b1, 1'b0);
                run_instr(K_BEQ, 1'b0, 1'b0);
                run_instr(K_JAL, 1'b0, 1'b0);
                run_instr(K_JR, 1'b0, 1'b0);
                run_instr(K_ORI, 1'b0, 1'b1);
                run_instr(K_LUI, 1'b0, 1'b1);
                run_instr(K_ADDI, 1'b0, 1'b1);
                run_instr(K_ADDIU, 1'b0, 1'b1);
                run_instr(K_J, 1'b0, 1'b1);
                repeat (80) begin
                    run_instr(kind_t'($urandom_range(0, 10)), 1'($urandom_range(0, 1)), 1'b1);
                end
                mon_en = 1'b0;
                check("sb_drain", 32'(sbq.size()), 32'd0);

                // Illegal opcode halts after DECODE and stays halted.
                reset = 1'b1; opcode = 6'b111111; mem_ready = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                step();
                step();
                @(negedge clk);
                check("ill_state", 32'(state), 32'(S_HALT));
                check("ill_halted", 32'(halted), 32'd1);
                check("ill_cause", 32'(halt_cause), 32'(HC_ILLEGAL));
                bad = 0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    mem_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (state != 4'(S_HALT) || !halted ||
                        (|{mem_read, mem_write, ir_write, mdr_write, pc_en, reg_write, instr_done}))
                        bad++;
                end
                check("ill_hold", 32'(bad), 32'd0);
                check("ill_cause_hold", 32'(halt_cause), 32'(HC_ILLEGAL));
                reset = 1'b1;
                #1;
                check("ill_reset_state", 32'(state), 32'(S_FETCH));
                check("ill_reset_halted", 32'(halted), 32'd0);
                check("ill_reset_cause", 32'(halt_cause), 32'(HC_NONE));

                // Fetch timeout: four waiting cycles, then HALT.
                mem_ready = 1'b0; opcode = OP_RTYPE;
                @(posedge clk); #1;
                reset = 1'b0;
                bad = 0;
                for (int i = 0; i < LIMIT; i++) begin
                    @(negedge clk);
                    if (state != 4'(S_FETCH) || !mem_read) bad++;
                    @(posedge clk); #1;
                end
                @(negedge clk);
                check("to_wait_cycles", 32'(bad), 32'd0);
                check("to_state", 32'(state), 32'(S_HALT));
                check("to_cause", 32'(halt_cause), 32'(HC_TIMEOUT));
                check("to_mem_read", 32'(mem_read), 32'd0);

                // Reset during a pending store drops mem_write immediately.
                @(posedge clk); #1;
                reset = 1'b1; opcode = OP_SW; mem_ready = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                step();
                mem_ready = 1'b0;
                step();
                step();
                @(negedge clk);
                check("wr_state", 32'(state), 32'(S_MEM_WR));
                check("wr_mem_write", 32'(mem_write), 32'd1);
                check("wr_iord", 32'(iord), 32'd1);
                #2;
                reset = 1'b1;
                #1;
                check("wr_rst_mem_write", 32'(mem_write), 32'd0);
                check("wr_rst_mem_read", 32'(mem_read), 32'd0);
                check("wr_rst_state", 32'(state), 32'(S_FETCH));
                @(posedge clk); #1;
                reset = 1'b0;
                step();
                done = 1'b1;
            end
            begin : monitor
                int         cyc;
                int         ir_cnt;
                int         mdr_cnt;
                logic [5:0] prev;
                exp_t       e;
                cyc = 0; ir_cnt = 0; mdr_cnt = 0; prev = 6'd0;
                while (!done) begin
                    @(negedge clk);
                    if (!mon_en) begin
                        cyc = 0; ir_cnt = 0; mdr_cnt = 0;
                    end else begin
                        cyc++;
                        if (ir_write) ir_cnt++;
                        if (mdr_write) begin
                            mdr_cnt++;
                            check("mdr_with_ready", 32'(mem_ready), 32'd1);
                        end
                        if (instr_done) begin
                            if (sbq.size() == 0) begin
                                check("sb_unexpected_done", 32'(sbq.size()), 32'd1);
                            end else begin
                                e = sbq.pop_front();
                                check("cycles", 32'(cyc), 32'(e.cycles));
                                check("last_cycle_ctrl",
                                      32'({reg_write, reg_dst, mem_to_reg, pc_en, pc_source, mem_write}),
                                      32'(e.sig));
                                check("mdr_pulses", 32'(mdr_cnt), 32'(e.mdr));
                                check("ir_pulses", 32'(ir_cnt), 32'd1);
                                if (e.chk_prev)
                                    check("exec_alu_ctrl", 32'(prev), 32'(e.prev));
                            end
                            cyc = 0; ir_cnt = 0; mdr_cnt = 0;
                        end
                    end
                    prev = {alu_src_a, alu_src_b, alu_op};
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencing controller for the MIPS core. It replaces the single-cycle decode with an FSM that steps a shared ALU/memory datapath through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. Each memory access is gated by a `mem_ready` handshake, so instruction and data memory can take a variable number of cycles. The block sits between the instruction register (opcode/funct) and the datapath muxes and enables; the existing ALU control unit consumes its `alu_op`.

## Interface
- `WAIT_LIMIT`, default 0: max cycles a memory state waits for `mem_ready`; 0 disables the timeout; legal range 0–255.
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: IR[31:26]; sampled in DECODE and later.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_en` out 1: PC load enable, equal to `pc_write | (pc_write_cond & zero)`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR load.
- `mdr_write` out 1: MDR load.
- `reg_write` out 1: register file write.
- `reg_dst` out 2: 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg` out 2: 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 3: 000 = B, 001 = 4, 010 = sign-ext imm, 011 = sign-ext imm<<2, 100 = zero-ext imm.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct, 11 = immediate logic.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump address, 11 = A.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `halted` out 1: sticky; set on entering HALT.
- `halt_cause` out 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.
- `state` out 4: current state code, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, HALT.
- **FETCH**
  - Assert `mem_read`, with `iord`=0, `alu_src_a`=0, `alu_src_b`=001, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle `mem_ready`=1, which also moves to DECODE. Otherwise stay in FETCH.
- **DECODE**
  - `alu_src_a`=0, `alu_src_b`=011, `alu_op`=00, so ALUOut receives the branch target.
  - Next state by opcode:
    - LW/SW → MEM_ADDR
    - R-type with funct 001000 → JR; other R-type → R_EXEC
    - ADDI/ADDIU/ORI/LUI → I_EXEC
    - BEQ → BRANCH
    - J → JUMP
    - JAL → JAL
    - anything else → HALT, cause 01
- **MEM_ADDR**: A + sign-ext (`alu_src_a`=1, `alu_src_b`=010, `alu_op`=00) → MEM_RD for LW, MEM_WR for SW.
- **MEM_RD**: `mem_read`, `iord`=1; `mdr_write` asserted in the `mem_ready` cycle, then → MEM_WB.
- **MEM_WB**: `reg_write`, `reg_dst`=00, `mem_to_reg`=01, `instr_done` → FETCH.
- **MEM_WR**: `mem_write`, `iord`=1; held until `mem_ready`; `instr_done` in that cycle → FETCH.
- **R_EXEC**: `alu_src_a`=1, `alu_src_b`=000, `alu_op`=10.
- **R_WB**: `reg_write`, `reg_dst`=01, `mem_to_reg`=00, `instr_done`.
- **I_EXEC**: `alu_src_a`=1, `alu_op`=11 for ORI/LUI, 00 for ADDI/ADDIU. `alu_src_b`=100 for ORI, 010 otherwise.
- **I_WB**: `reg_write`, `reg_dst`=00, `mem_to_reg`=00, `instr_done`.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=000, `alu_op`=01, `pc_write_cond`, `pc_source`=01, `instr_done`.
- **JUMP**: `pc_write`, `pc_source`=10, `instr_done`.
- **JAL**: `pc_write`, `pc_source`=10, `reg_write`, `reg_dst`=10, `mem_to_reg`=10, `instr_done`. PC already holds PC+4 and is written into $31 in the same edge the PC updates.
- **JR**: `pc_write`, `pc_source`=11, `instr_done`.
- **HALT**
  - All enables are 0 and `halted`=1; the state is held until reset.
  - `halt_cause` latches on entry and never changes afterwards.
- Wait counter (8-bit)
  - Clears on every entry to FETCH, MEM_RD or MEM_WR, and increments each wait cycle.
  - If `WAIT_LIMIT`≠0 and the count reaches `WAIT_LIMIT` without `mem_ready`, go to HALT with cause 10 and drop all requests.
- Unlisted outputs are 0 in every state.

## Timing
- Outputs decode from the state; `ir_write`, `mdr_write`, `pc_write` in FETCH and `instr_done` in MEM_WR are additionally qualified by `mem_ready` (Mealy).
- CPI with `mem_ready` held at 1: LW 5; SW, R-type, I-type 4; BEQ, J, JAL, JR 3.
- Each cycle with `mem_ready`=0 in a memory state adds one cycle.
- While `reset` is high:
  - `state` = FETCH (0), all enables 0 (including `mem_read`), `halted` 0, `halt_cause` 00, wait counter 0.
- Reset asserted mid-instruction abandons any outstanding memory access immediately. The first fetch begins on the first rising edge after `reset` deasserts.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct constants;
  - state encodings;
  - `reg_dst`, `mem_to_reg`, `alu_src_b`, `alu_op`, `pc_source` select encodings;
  - `halt_cause` codes.
- Single module with no sub-modules: a state register, next-state logic, output decode and the wait counter.

## Test plan
- ADDU with `mem_ready`=1: `state` sequence 0→1→R_EXEC→R_WB→0; `reg_dst`=01 in R_WB; `instr_done` high only in that cycle.
- LW with `mem_ready` low for 3 cycles in MEM_RD: LW takes 8 cycles; `mdr_write` pulses exactly once, aligned with `mem_ready`.
- BEQ with `zero`=1 then `zero`=0: `pc_en` is 1 then 0 in the BRANCH cycle; `pc_source`=01 in both.
- JAL: in one cycle `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10, `pc_en`=1, `pc_source`=10.
- Opcode 111111: the state after DECODE is HALT with `halted`=1 and `halt_cause`=01, and stays there for 20 cycles; a reset pulse returns `state` to 0.
- `WAIT_LIMIT`=4 with `mem_ready` held 0 in FETCH: HALT with cause 10 after 4 cycles. Separately, assert reset mid-MEM_WR: `mem_write` drops to 0 immediately.
